// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller and its register bank.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package tetris_pkg;

    localparam int DEF_MEM_WIDTH  = 10;
    localparam int DEF_MEM_HEIGHT = 20;
    localparam int DEF_WIDTH      = 8;

    localparam logic [7:0] FIG_I = 8'h00;
    localparam logic [7:0] FIG_Q = 8'h01;

    // Spawn coordinates, block0 in the MSB slice.
    localparam logic [4*DEF_WIDTH-1:0] SPAWN_I_X = {8'd3, 8'd4, 8'd5, 8'd6};
    localparam logic [4*DEF_WIDTH-1:0] SPAWN_I_Y = {8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [4*DEF_WIDTH-1:0] SPAWN_Q_X = {8'd4, 8'd4, 8'd5, 8'd5};
    localparam logic [4*DEF_WIDTH-1:0] SPAWN_Q_Y = {8'd0, 8'd1, 8'd0, 8'd1};

    typedef enum logic [2:0] {
        S_WAIT,
        S_CHECK,
        S_COMMIT,
        S_COMMIT_LAND,
        S_SPAWN,
        S_SPAWN_CHK,
        S_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

endpackage

// File: rtl/fall_ctrl_if.sv
// Bus between the piece-motion controller and the border/position register bank.
// Latency: none (wires only).
// Backpressure: none; write_reg / is_load_fig are single-cycle strobes the bank must take.
// master = controller: takes buttons, rho_x/rho_y, border; drives new_*, strobes, figure, game_over.
// slave  = register bank / stimulus side, the mirror image.
interface fall_ctrl_if
    import tetris_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int WIDTH     = DEF_WIDTH
);
    logic                       btn_left;
    logic                       btn_right;
    logic                       btn_down;
    logic [4*WIDTH-1:0]         rho_x;
    logic [4*WIDTH-1:0]         rho_y;
    logic [MEM_WIDTH*WIDTH-1:0] border;
    logic [4*WIDTH-1:0]         new_rho_x;
    logic [4*WIDTH-1:0]         new_rho_y;
    logic [MEM_WIDTH*WIDTH-1:0] new_border;
    logic                       write_reg;
    logic                       is_load_fig;
    logic [WIDTH-1:0]           figure;
    logic                       game_over;

    modport master (
        input  btn_left, btn_right, btn_down, rho_x, rho_y, border,
        output new_rho_x, new_rho_y, new_border, write_reg, is_load_fig, figure, game_over
    );

    modport slave (
        output btn_left, btn_right, btn_down, rho_x, rho_y, border,
        input  new_rho_x, new_rho_y, new_border, write_reg, is_load_fig, figure, game_over
    );
endinterface

// File: rtl/fig_collide.sv
// Legality check of a 4-block piece against the per-column border.
// Latency: combinational.
// Backpressure: none.
// Ports: blk_x/blk_y (4 packed coordinates), border (column 0 in MSB slice) -> legal.
module fig_collide
    import tetris_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic [4*WIDTH-1:0]         blk_x,
    input  logic [4*WIDTH-1:0]         blk_y,
    input  logic [MEM_WIDTH*WIDTH-1:0] border,
    output logic                       legal
);
    logic blk_ok;

    always_comb begin
        legal  = 1'b1;
        blk_ok = 1'b0;
        for (int b = 0; b < 4; b++) begin
            // Only an exact column match can make a block legal, so any
            // x >= MEM_WIDTH (including a wrapped 0-1) fails naturally.
            blk_ok = 1'b0;
            for (int c = 0; c < MEM_WIDTH; c++) begin
                if (blk_x[b*WIDTH +: WIDTH] == WIDTH'(c) &&
                    blk_y[b*WIDTH +: WIDTH] < border[(MEM_WIDTH-1-c)*WIDTH +: WIDTH])
                    blk_ok = 1'b1;
            end
            // A border entry never exceeds the floor; guard against a corrupt one.
            if (blk_y[b*WIDTH +: WIDTH] >= WIDTH'(MEM_HEIGHT))
                blk_ok = 1'b0;
            legal = legal & blk_ok;
        end
    end
endmodule

// File: rtl/fall_ctrl.sv
// Piece-motion controller: buttons + gravity -> candidate moves, landing, respawn, game over.
// Latency: event sampled in WAIT at t -> write_reg at t+2; landing -> is_load_fig at t+3.
// Backpressure: none; button pulses outside WAIT are dropped, gravity is held pending.
// Ports: clk, rst (async active-low), bus (fall_ctrl_if.master).
module fall_ctrl
    import tetris_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FALL_DIV   = 50
) (
    input  logic        clk,
    input  logic        rst,
    fall_ctrl_if.master bus
);
    localparam int               CNT_W    = (FALL_DIV > 2) ? $clog2(FALL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_DIV - 1);

    state_t                     state, state_nxt;
    dir_t                       dir, dir_nxt;
    logic [CNT_W-1:0]           grav_cnt;
    logic                       grav_pend;
    logic                       take_down;
    logic [4*WIDTH-1:0]         cand_x, cand_y;
    logic [4*WIDTH-1:0]         chk_x, chk_y;
    logic [MEM_WIDTH*WIDTH-1:0] land_border;
    logic                       legal;

    // Candidate position and the border a landing would leave behind.
    always_comb begin
        cand_x      = bus.rho_x;
        cand_y      = bus.rho_y;
        land_border = bus.border;
        for (int b = 0; b < 4; b++) begin
            unique case (dir)
                DIR_LEFT:  cand_x[b*WIDTH +: WIDTH] = bus.rho_x[b*WIDTH +: WIDTH] - WIDTH'(1);
                DIR_RIGHT: cand_x[b*WIDTH +: WIDTH] = bus.rho_x[b*WIDTH +: WIDTH] + WIDTH'(1);
                default:   cand_y[b*WIDTH +: WIDTH] = bus.rho_y[b*WIDTH +: WIDTH] + WIDTH'(1);
            endcase
            for (int c = 0; c < MEM_WIDTH; c++) begin
                if (bus.rho_x[b*WIDTH +: WIDTH] == WIDTH'(c) &&
                    bus.rho_y[b*WIDTH +: WIDTH] < land_border[(MEM_WIDTH-1-c)*WIDTH +: WIDTH])
                    land_border[(MEM_WIDTH-1-c)*WIDTH +: WIDTH] = bus.rho_y[b*WIDTH +: WIDTH];
            end
        end
    end

    // One checker serves both the move candidate and the freshly spawned piece.
    assign chk_x = (state == S_SPAWN_CHK) ? bus.rho_x : cand_x;
    assign chk_y = (state == S_SPAWN_CHK) ? bus.rho_y : cand_y;

    fig_collide #(
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_HEIGHT (MEM_HEIGHT),
        .WIDTH      (WIDTH)
    ) u_collide (
        .blk_x  (chk_x),
        .blk_y  (chk_y),
        .border (bus.border),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_WAIT;
            dir   <= DIR_DOWN;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        dir_nxt         = dir;
        take_down       = 1'b0;
        bus.write_reg   = 1'b0;
        bus.is_load_fig = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (bus.btn_down || grav_pend) begin
                    dir_nxt   = DIR_DOWN;
                    take_down = 1'b1;
                    state_nxt = S_CHECK;
                end else if (bus.btn_left) begin
                    dir_nxt   = DIR_LEFT;
                    state_nxt = S_CHECK;
                end else if (bus.btn_right) begin
                    dir_nxt   = DIR_RIGHT;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (legal)                  state_nxt = S_COMMIT;
                else if (dir == DIR_DOWN)   state_nxt = S_COMMIT_LAND;
                else                        state_nxt = S_WAIT;
            end
            S_COMMIT: begin
                bus.write_reg = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_COMMIT_LAND: begin
                bus.write_reg = 1'b1;
                state_nxt     = S_SPAWN;
            end
            S_SPAWN: begin
                bus.is_load_fig = 1'b1;
                state_nxt       = S_SPAWN_CHK;
            end
            S_SPAWN_CHK: state_nxt = legal ? S_WAIT : S_OVER;
            S_OVER:      state_nxt = S_OVER;
            default:     state_nxt = S_WAIT;
        endcase
    end

    // Gravity: a tick arriving in the same cycle a down move is taken wins,
    // so no gravity step is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (take_down)
                grav_pend <= 1'b0;
            if (state != S_OVER) begin
                if (grav_cnt == CNT_LAST) begin
                    grav_cnt  <= '0;
                    grav_pend <= 1'b1;
                end else begin
                    grav_cnt <= grav_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.new_rho_x  <= '0;
            bus.new_rho_y  <= '0;
            bus.new_border <= '0;
            bus.figure     <= WIDTH'(FIG_I);
            bus.game_over  <= 1'b0;
        end else begin
            if (state == S_CHECK) begin
                if (legal) begin
                    bus.new_rho_x  <= cand_x;
                    bus.new_rho_y  <= cand_y;
                    bus.new_border <= bus.border;
                end else if (dir == DIR_DOWN) begin
                    // Piece stays put; its blocks become the new column tops.
                    bus.new_rho_x  <= bus.rho_x;
                    bus.new_rho_y  <= bus.rho_y;
                    bus.new_border <= land_border;
                end
            end
            if (state == S_COMMIT_LAND)
                bus.figure <= (bus.figure == WIDTH'(FIG_I)) ? WIDTH'(FIG_Q) : WIDTH'(FIG_I);
            if (state == S_SPAWN_CHK && !legal)
                bus.game_over <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fall_ctrl.sv
// Directed bench for fall_ctrl with a behavioural register bank closing the loop.
// Latency: n/a.
// Backpressure: n/a.
module tb_fall_ctrl;
    import tetris_pkg::*;

    localparam int MW = 10;
    localparam int W  = 8;
    localparam int FD = 50;

    logic clk;
    logic rst;

    fall_ctrl_if #(.MEM_WIDTH(MW), .WIDTH(W)) bus();

    fall_ctrl #(
        .MEM_WIDTH  (MW),
        .MEM_HEIGHT (20),
        .WIDTH      (W),
        .FALL_DIV   (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int ld_cnt  = 0;
    int both_hi = 0;

    logic          pre_vld;
    logic [31:0]   pre_x, pre_y;
    logic [79:0]   pre_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: preload, move/land write, or spawn reload.
    always @(posedge clk) begin
        if (pre_vld) begin
            bus.rho_x  <= pre_x;
            bus.rho_y  <= pre_y;
            bus.border <= pre_b;
        end else if (bus.write_reg) begin
            bus.rho_x  <= bus.new_rho_x;
            bus.rho_y  <= bus.new_rho_y;
            bus.border <= bus.new_border;
            wr_cnt     <= wr_cnt + 1;
        end else if (bus.is_load_fig) begin
            bus.rho_x  <= (bus.figure == FIG_Q) ? SPAWN_Q_X : SPAWN_I_X;
            bus.rho_y  <= (bus.figure == FIG_Q) ? SPAWN_Q_Y : SPAWN_I_Y;
            ld_cnt     <= ld_cnt + 1;
        end
        if (bus.write_reg && bus.is_load_fig)
            both_hi <= both_hi + 1;
    end

    function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    function automatic logic [79:0] bfill(input int v);
        logic [79:0] r;
        r = '0;
        for (int c = 0; c < MW; c++) r[(MW-1-c)*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [79:0] bset(input logic [79:0] b, input int c, input int v);
        logic [79:0] r;
        r = b;
        r[(MW-1-c)*8 +: 8] = 8'(v);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] x, input logic [31:0] y, input logic [79:0] b);
        @(negedge clk);
        rst = 1'b0; pre_vld = 1'b1; pre_x = x; pre_y = y; pre_b = b;
        @(negedge clk);
        rst = 1'b1; pre_vld = 1'b0;
    endtask

    task automatic press(input logic l, input logic r, input logic d);
        bus.btn_left = l; bus.btn_right = r; bus.btn_down = d;
        @(negedge clk);
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_down = 1'b0;
    endtask

    task automatic wait_wr(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.write_reg && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.write_reg, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, l0;
        logic [79:0] exp_b;

        rst = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_down = 1'b0;
        pre_vld = 1'b1; pre_x = p4(3, 4, 5, 6); pre_y = p4(0, 0, 0, 0); pre_b = bfill(6);

        // Reset state
        @(negedge clk);
        chk("rst_write_reg", bus.write_reg, 1'b0);
        chk("rst_is_load_fig", bus.is_load_fig, 1'b0);
        chk("rst_figure", bus.figure, 8'h00);
        chk("rst_game_over", bus.game_over, 1'b0);
        chk("rst_new_rho_x", bus.new_rho_x, 32'h0);
        chk("rst_new_rho_y", bus.new_rho_y, 32'h0);
        chk("rst_new_border", bus.new_border, 80'h0);
        rst = 1'b1; pre_vld = 1'b0;
        @(negedge clk);

        // Legal right move: strobe at t+2, position visible at t+3
        press(1'b0, 1'b1, 1'b0);
        chk("right_t1_no_wr", bus.write_reg, 1'b0);
        @(negedge clk);
        chk("right_t2_wr", bus.write_reg, 1'b1);
        chk("right_new_x", bus.new_rho_x, p4(4, 5, 6, 7));
        chk("right_new_y", bus.new_rho_y, p4(0, 0, 0, 0));
        chk("right_new_border", bus.new_border, bfill(6));
        @(negedge clk);
        chk("right_t3_wr_low", bus.write_reg, 1'b0);
        chk("right_rho_x", bus.rho_x, p4(4, 5, 6, 7));

        // Right edge: illegal, no write, then back in WAIT accepting a left
        do_reset(p4(6, 7, 8, 9), p4(0, 0, 0, 0), bfill(6));
        w0 = wr_cnt;
        press(1'b0, 1'b1, 1'b0);
        cyc(3);
        chk("right_edge_no_wr", wr_cnt - w0, 0);
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_edge_left_wr", bus.write_reg, 1'b1);
        chk("after_edge_left_x", bus.new_rho_x, p4(5, 6, 7, 8));

        // Left edge: 0-1 wraps to 255, illegal
        do_reset(p4(0, 1, 2, 3), p4(0, 0, 0, 0), bfill(6));
        w0 = wr_cnt;
        press(1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("left_edge_no_wr", wr_cnt - w0, 0);
        chk("left_edge_rho_x", bus.rho_x, p4(0, 1, 2, 3));

        // Down beats left; a left during CHECK is dropped
        do_reset(p4(3, 4, 5, 6), p4(0, 0, 0, 0), bfill(6));
        w0 = wr_cnt;
        press(1'b1, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk("prio_wr", bus.write_reg, 1'b1);
        chk("prio_new_x", bus.new_rho_x, p4(3, 4, 5, 6));
        chk("prio_new_y", bus.new_rho_y, p4(1, 1, 1, 1));
        cyc(4);
        chk("prio_single_wr", wr_cnt - w0, 1);
        chk("prio_rho_x", bus.rho_x, p4(3, 4, 5, 6));

        // Gravity: five falls to y=5, then landing and Q spawn
        do_reset(p4(3, 4, 5, 6), p4(0, 0, 0, 0), bfill(6));
        l0 = ld_cnt;
        for (int k = 1; k <= 5; k++) begin
            wait_wr(120, "grav_wr");
            chk("grav_new_y", bus.new_rho_y, p4(k, k, k, k));
            @(negedge clk);
        end
        chk("grav_rho_y5", bus.rho_y, p4(5, 5, 5, 5));
        wait_wr(120, "land_wr");
        exp_b = bfill(6);
        for (int c = 3; c <= 6; c++) exp_b = bset(exp_b, c, 5);
        chk("land_new_border", bus.new_border, exp_b);
        chk("land_new_y", bus.new_rho_y, p4(5, 5, 5, 5));
        @(negedge clk);
        chk("land_load_fig", bus.is_load_fig, 1'b1);
        chk("land_load_no_wr", bus.write_reg, 1'b0);
        chk("land_figure_q", bus.figure, 8'h01);
        @(negedge clk);
        chk("land_load_one_cyc", bus.is_load_fig, 1'b0);
        cyc(2);
        chk("land_no_game_over", bus.game_over, 1'b0);
        chk("land_spawn_x", bus.rho_x, SPAWN_Q_X);
        chk("land_one_load", ld_cnt - l0, 1);

        // Blocked spawn -> game over, then no strobes
        do_reset(p4(3, 4, 5, 6), p4(0, 0, 0, 0), bset(bfill(6), 4, 1));
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        exp_b = bfill(6);
        for (int c = 3; c <= 6; c++) exp_b = bset(exp_b, c, 0);
        chk("go_land_wr", bus.write_reg, 1'b1);
        chk("go_land_border", bus.new_border, exp_b);
        @(negedge clk);
        chk("go_load_fig", bus.is_load_fig, 1'b1);
        cyc(2);
        chk("go_game_over", bus.game_over, 1'b1);
        w0 = wr_cnt; l0 = ld_cnt;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        cyc(100);
        chk("over_no_wr", wr_cnt - w0, 0);
        chk("over_no_load", ld_cnt - l0, 0);
        chk("over_sticky", bus.game_over, 1'b1);
        chk("over_figure_hold", bus.figure, 8'h01);

        // Reset during COMMIT_LAND
        do_reset(p4(3, 4, 5, 6), p4(5, 5, 5, 5), bfill(6));
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_pre_wr", bus.write_reg, 1'b1);
        l0 = ld_cnt;
        rst = 1'b0;
        #1;
        chk("abort_write_reg", bus.write_reg, 1'b0);
        chk("abort_figure", bus.figure, 8'h00);
        chk("abort_new_border", bus.new_border, 80'h0);
        chk("abort_new_rho_y", bus.new_rho_y, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(5);
        chk("abort_no_load", ld_cnt - l0, 0);
        chk("abort_figure_after", bus.figure, 8'h00);

        chk("strobe_exclusive", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fall_ctrl.md
Name: fall_ctrl

Overview:
Piece-motion controller directly upstream of the border/position register bank. Turns debounced button pulses and an internal gravity timer into candidate block positions and checks each candidate against the per-column border. It produces the new_border, new_rho_x, new_rho_y, write_reg, is_load_fig and figure signals that the register bank consumes. It also detects landing and game over.

Parameters:
MEM_WIDTH, 10, playfield columns
MEM_HEIGHT, 20, playfield rows (y grows downward)
WIDTH, 8, bits per coordinate / border entry
FALL_DIV, 50, clk cycles between gravity steps (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
btn_left  in  1  single-cycle move-left pulse
btn_right  in  1  single-cycle move-right pulse
btn_down  in  1  single-cycle soft-drop pulse
rho_x  in  4*WIDTH  current block x, block0 in MSB slice
rho_y  in  4*WIDTH  current block y, same order
border  in  MEM_WIDTH*WIDTH  per-column first blocked row, column 0 in MSB slice
new_rho_x  out  4*WIDTH  candidate x to write
new_rho_y  out  4*WIDTH  candidate y to write
new_border  out  MEM_WIDTH*WIDTH  border to write
write_reg  out  1  one-cycle load strobe for the register bank
is_load_fig  out  1  one-cycle spawn strobe; register bank reloads spawn coords
figure  out  WIDTH  current figure code: 8'h00 = I, 8'h01 = Q
game_over  out  1  sticky; high until reset

Behaviour:
- Reset (rst=0, async): state WAIT. All outputs 0; figure=8'h00. Gravity counter 0, pending flag 0.
- Legality: block (x,y) is legal iff x < MEM_WIDTH and y < border[x], both unsigned. A piece is legal iff all 4 blocks are legal. x=0 minus 1 wraps to 255 and is therefore illegal.
- Gravity counter: increments every cycle while state != OVER. At FALL_DIV-1 it sets grav_pend and wraps to 0. grav_pend clears when a down move is taken.
- Button pulses are accepted only in WAIT. Pulses arriving in any other state are dropped. grav_pend is never dropped.
- WAIT: choose the event by priority: down (btn_down or grav_pend) > left > right. Register the direction, go to CHECK. With no event, stay in WAIT.
- CHECK: compute the candidate (x-1, x+1 or y+1 for all 4 blocks).
  - Legal: register new_rho = candidate, new_border = border, go to COMMIT.
  - Illegal left/right: go to WAIT with no write.
  - Illegal down: register new_rho = rho, new_border[c] = min(border[c], y) for each block in column c, go to COMMIT_LAND.
- COMMIT: write_reg=1 for this cycle; go to WAIT.
- COMMIT_LAND: write_reg=1; figure toggles (00<->01) at the end of this cycle; go to SPAWN.
- SPAWN: is_load_fig=1, write_reg=0 for one cycle; go to SPAWN_CHK.
- SPAWN_CHK: the register bank now holds the spawn coordinates. If the piece is legal, go to WAIT. Otherwise set game_over=1 and go to OVER.
- OVER: terminal; outputs hold, no strobes. Exit only by reset.
- Latency: an event sampled in WAIT at cycle t gives write_reg at cycle t+2, new position visible on rho at t+3. Landing gives is_load_fig at t+3.
- write_reg and is_load_fig are never high in the same cycle.
- Reset mid-operation aborts immediately; pending strobes and grav_pend are lost.

Decomposition:
- Shared package tetris_pkg holds:
  - figure codes FIG_I=8'h00, FIG_Q=8'h01
  - spawn coordinate constants
  - FSM state encoding
  - default MEM_WIDTH, MEM_HEIGHT, WIDTH
- One sub-module, fig_collide: combinational; inputs are 4 (x,y) pairs plus border, output is a legal flag. Instantiated once on the candidate and reused in SPAWN_CHK on rho.

Test Plan:
- Reset, border all 6, I at x=3..6, y=0. btn_right -> write_reg at t+2, new_rho_x = 4,5,6,7, new_rho_y = 0,0,0,0.
- I at x=6..9, btn_right -> no write_reg; state returns to WAIT. I at x=0..3, btn_left -> no write_reg.
- Let gravity run with border all 6 -> five writes reaching y=5. Next down is illegal -> COMMIT_LAND with new_border cols 3..6 = 5, others 6. Then figure=8'h01, is_load_fig for one cycle, game_over stays 0.
- btn_down and btn_left in the same WAIT cycle -> only the down move is written. A btn_left during CHECK is ignored.
- Preload border[4]=1, spawn Q (4,0)(4,1)(5,0)(5,1) -> SPAWN_CHK illegal, game_over=1. Further buttons produce no strobes until rst=0.
- Assert rst=0 during COMMIT_LAND -> all outputs 0 asynchronously, figure=8'h00, no is_load_fig after release.
